// File: rtl/param.vh
// Shared build-time constants for the wormhole arbiter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

// File: rtl/wormhole_arb3.sv
// Three-input wormhole arbiter: round-robin between packets, locks to one
// requester from head to tail, one-flit-per-cycle registered output.
//
// state | meaning
// IDLE  | no packet open; pick first valid requester from ptr
// LOCK  | packet open; only owner may send until its tail
`include "param.vh"

module wormhole_arb3 (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [`DATA_WIDTH-1:0] A_data_i,
  input  logic [`DATA_WIDTH-1:0] B_data_i,
  input  logic [`DATA_WIDTH-1:0] C_data_i,
  input  logic                   A_valid_i,
  input  logic                   B_valid_i,
  input  logic                   C_valid_i,
  output logic                   A_ready_o,
  output logic                   B_ready_o,
  output logic                   C_ready_o,
  output logic [`DATA_WIDTH-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [2:0]             grant_o,
  output logic [15:0]            pkt_cnt_o,
  output logic                   err_o
);

  localparam int W = `DATA_WIDTH;
  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state_q, state_d;
  logic [1:0]     owner_q, owner_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [2:0]     vld;
  logic           slot_free;
  logic [1:0]     sel;
  logic           sel_found;
  logic           accept;
  logic [W-1:0]   sel_data;
  logic [1:0]     sel_type;

  function automatic logic [1:0] wrap3(input logic [2:0] s);
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_comb begin
    vld       = {C_valid_i, B_valid_i, A_valid_i};
    slot_free = !valid_q || ready_i;
    sel       = ptr_q;
    sel_found = 1'b0;
    if (state_q == LOCK) begin
      sel       = owner_q;
      sel_found = vld[owner_q];
    end else begin
      // Walk backwards so the candidate closest to ptr is the last to be written.
      for (int k = 2; k >= 0; k--) begin
        if (vld[wrap3(3'(ptr_q) + 3'(k))]) begin
          sel       = wrap3(3'(ptr_q) + 3'(k));
          sel_found = 1'b1;
        end
      end
    end
    accept = sel_found && slot_free && rstn;
    case (sel)
      2'd1:    sel_data = B_data_i;
      2'd2:    sel_data = C_data_i;
      default: sel_data = A_data_i;
    endcase
    sel_type = sel_data[W-1:W-2];
  end

  assign A_ready_o = accept && (sel == 2'd0);
  assign B_ready_o = accept && (sel == 2'd1);
  assign C_ready_o = accept && (sel == 2'd2);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (accept) begin
      data_d  = sel_data;
      valid_d = 1'b1;
      if (state_q == IDLE) begin
        case (sel_type)
          T_HEAD: begin
            state_d = LOCK;
            owner_d = sel;
          end
          T_SINGLE: begin
            ptr_d = wrap3(3'(sel) + 3'd1);
            cnt_d = cnt_q + 16'd1;
          end
          default: begin
            // Orphan body/tail: pass it on but close it as its own packet.
            ptr_d = wrap3(3'(sel) + 3'd1);
            cnt_d = cnt_q + 16'd1;
            err_d = 1'b1;
          end
        endcase
      end else begin
        case (sel_type)
          T_TAIL: begin
            state_d = IDLE;
            ptr_d   = wrap3(3'(owner_q) + 3'd1);
            cnt_d   = cnt_q + 16'd1;
          end
          T_BODY:  ;
          default: err_d = 1'b1;
        endcase
      end
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign grant_o   = (state_q == LOCK) ? (3'b001 << owner_q) : 3'b000;
  assign pkt_cnt_o = cnt_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_wormhole_arb3.sv
// Bench for wormhole_arb3: directed scenarios plus random traffic against a
// packet-level reference model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_wormhole_arb3;
  localparam int W = `DATA_WIDTH;
  localparam logic [1:0] HD = 2'b10, BD = 2'b00, TL = 2'b01, SG = 2'b11;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] d [3];
  logic         v [3];
  logic         ready_i;
  logic         A_ready_o, B_ready_o, C_ready_o;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic [2:0]   grant_o;
  logic [15:0]  pkt_cnt_o;
  logic         err_o;

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the packet (-1 none), rotation start, counters.
  int           m_lock, m_ptr;
  logic [15:0]  m_cnt;
  logic         m_err, m_valid;
  logic [W-1:0] m_data;

  wormhole_arb3 dut (
    .clk(clk), .rstn(rstn),
    .A_data_i(d[0]), .B_data_i(d[1]), .C_data_i(d[2]),
    .A_valid_i(v[0]), .B_valid_i(v[1]), .C_valid_i(v[2]),
    .A_ready_o(A_ready_o), .B_ready_o(B_ready_o), .C_ready_o(C_ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .grant_o(grant_o), .pkt_cnt_o(pkt_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int id, input int seq);
    logic [W-3:0] p;
    p = (W-2)'(id * 256 + seq);
    return {t, p};
  endfunction

  task automatic model_reset();
    m_lock = -1; m_ptr = 0; m_cnt = 16'd0; m_err = 1'b0; m_valid = 1'b0; m_data = '0;
  endtask

  function automatic int pick();
    if (m_valid && !ready_i) return -1;
    if (m_lock >= 0) return v[m_lock] ? m_lock : -1;
    for (int k = 0; k < 3; k++)
      if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready(input int w);
    return (w < 0) ? 3'b000 : 3'(1 << w);
  endfunction

  function automatic logic [2:0] exp_grant();
    return (m_lock < 0) ? 3'b000 : 3'(1 << m_lock);
  endfunction

  task automatic model_commit(input int w);
    logic [1:0] t;
    logic       free;
    free = !m_valid || ready_i;
    if (w >= 0) begin
      t = d[w][W-1:W-2];
      m_data = d[w];
      m_valid = 1'b1;
      if (m_lock < 0) begin
        if (t == HD) m_lock = w;
        else begin
          m_ptr = (w + 1) % 3;
          m_cnt = m_cnt + 16'd1;
          if (t != SG) m_err = 1'b1;
        end
      end else if (t == TL) begin
        m_ptr = (m_lock + 1) % 3;
        m_cnt = m_cnt + 16'd1;
        m_lock = -1;
      end else if (t != BD) begin
        m_err = 1'b1;
      end
    end else if (free) begin
      m_valid = 1'b0;
    end
  endtask

  // Entered and left at posedge+1; samples combinational outputs mid-cycle.
  task automatic run_cycle(output int w, output logic [2:0] rdy, output logic [2:0] gnt);
    #3;
    w = pick();
    rdy = {C_ready_o, B_ready_o, A_ready_o};
    gnt = grant_o;
    @(posedge clk);
    model_commit(w);
    #1;
  endtask

  task automatic idle_inputs();
    for (int j = 0; j < 3; j++) begin v[j] = 1'b0; d[j] = '0; end
  endtask

  task automatic test_reset();
    int w; logic [2:0] r, g;
    for (int j = 0; j < 3; j++) begin v[j] = 1'b1; d[j] = mk(SG, j, 0); end
    ready_i = 1'b1;
    #2;
    total++; if ({C_ready_o, B_ready_o, A_ready_o} !== 3'b000) begin bad++; $display("FAIL rst_ready: got %b want 000", {C_ready_o, B_ready_o, A_ready_o}); end
    @(posedge clk); #1;
    total++; if ({valid_o, grant_o, pkt_cnt_o, err_o, data_o} !== '0) begin bad++; $display("FAIL rst_outputs: valid=%b grant=%b cnt=%h err=%b data=%h want all 0", valid_o, grant_o, pkt_cnt_o, err_o, data_o); end
    rstn = 1'b1;
    model_reset();
    idle_inputs();
    run_cycle(w, r, g);
  endtask

  task automatic test_round_robin();
    int w; logic [2:0] r, g;
    logic [15:0] base;
    base = m_cnt;
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 3; j++) begin v[j] = 1'b1; d[j] = mk(SG, j, i); end
      run_cycle(w, r, g);
      total++; if (r !== 3'(1 << (i % 3))) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, r, 3'(1 << (i % 3))); end
      total++; if (!valid_o || data_o !== mk(SG, i % 3, i)) begin bad++; $display("FAIL rr_data[%0d]: got %b/%h want 1/%h", i, valid_o, data_o, mk(SG, i % 3, i)); end
    end
    total++; if (pkt_cnt_o !== base + 16'd6) begin bad++; $display("FAIL rr_count: got %0d want %0d", pkt_cnt_o, base + 16'd6); end
    idle_inputs();
    run_cycle(w, r, g);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rr_drain: valid_o got %b want 0", valid_o); end
  endtask

  task automatic test_wormhole();
    int w; logic [2:0] r, g;
    logic [1:0] ty [4];
    logic [W-1:0] outs [$];
    logic [15:0] base;
    int ai; bit bdone;
    ty[0] = HD; ty[1] = BD; ty[2] = BD; ty[3] = TL;
    base = m_cnt; ai = 0; bdone = 0; ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      v[0] = (ai < 4); d[0] = mk(ty[ai % 4], 0, ai);
      v[1] = !bdone;   d[1] = mk(SG, 1, 0);
      v[2] = 1'b0;
      run_cycle(w, r, g);
      total++; if (r !== exp_ready(w)) begin bad++; $display("FAIL wh_ready[%0d]: got %b want %b", c, r, exp_ready(w)); end
      if (w == 0 && ai > 0 && ai < 3) begin
        total++; if (g !== 3'b001) begin bad++; $display("FAIL wh_grant[%0d]: got %b want 001", c, g); end
      end
      if (w == 0) ai++;
      if (w == 1) bdone = 1;
      if (valid_o) outs.push_back(data_o);
    end
    total++; if (outs.size() != 5) begin bad++; $display("FAIL wh_len: got %0d want 5", outs.size()); end
    for (int k = 0; k < 5 && k < outs.size(); k++) begin
      total++;
      if (outs[k] !== ((k < 4) ? mk(ty[k], 0, k) : mk(SG, 1, 0))) begin
        bad++; $display("FAIL wh_order[%0d]: got %h want %h", k, outs[k], (k < 4) ? mk(ty[k], 0, k) : mk(SG, 1, 0));
      end
    end
    total++; if (pkt_cnt_o !== base + 16'd2) begin bad++; $display("FAIL wh_count: got %0d want %0d", pkt_cnt_o, base + 16'd2); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int w; logic [2:0] r, g;
    ready_i = 1'b1;
    v[0] = 1'b1; d[0] = mk(HD, 0, 0);
    run_cycle(w, r, g);
    d[0] = mk(BD, 0, 1);
    ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      run_cycle(w, r, g);
      total++; if (r !== 3'b000) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 000", c, r); end
      total++; if (valid_o !== 1'b1 || data_o !== mk(HD, 0, 0)) begin bad++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", c, valid_o, data_o, mk(HD, 0, 0)); end
      total++; if (grant_o !== 3'b001) begin bad++; $display("FAIL bp_grant[%0d]: got %b want 001", c, grant_o); end
    end
    ready_i = 1'b1;
    run_cycle(w, r, g);
    total++; if (r !== 3'b001 || data_o !== mk(BD, 0, 1)) begin bad++; $display("FAIL bp_body: ready %b data %h want 001/%h", r, data_o, mk(BD, 0, 1)); end
    d[0] = mk(TL, 0, 2);
    run_cycle(w, r, g);
    total++; if (data_o !== mk(TL, 0, 2) || grant_o !== 3'b000) begin bad++; $display("FAIL bp_tail: data %h grant %b want %h/000", data_o, grant_o, mk(TL, 0, 2)); end
    idle_inputs();
    run_cycle(w, r, g);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_drain: valid_o got %b want 0", valid_o); end
  endtask

  task automatic test_err_body();
    int w; logic [2:0] r, g;
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL eb_pre: err_o got %b want 0", err_o); end
    ready_i = 1'b1;
    v[2] = 1'b1; d[2] = mk(BD, 2, 7);
    run_cycle(w, r, g);
    total++; if (valid_o !== 1'b1 || data_o !== mk(BD, 2, 7)) begin bad++; $display("FAIL eb_fwd: got %b/%h want 1/%h", valid_o, data_o, mk(BD, 2, 7)); end
    total++; if (err_o !== 1'b1 || grant_o !== 3'b000) begin bad++; $display("FAIL eb_err: err %b grant %b want 1/000", err_o, grant_o); end
    for (int j = 0; j < 3; j++) begin v[j] = 1'b1; d[j] = mk(SG, j, 8); end
    run_cycle(w, r, g);
    total++; if (r !== 3'b001 || data_o !== mk(SG, 0, 8)) begin bad++; $display("FAIL eb_ptr: ready %b data %h want 001/%h", r, data_o, mk(SG, 0, 8)); end
    idle_inputs();
    run_cycle(w, r, g);
    run_cycle(w, r, g);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL eb_sticky: err_o got %b want 1", err_o); end
  endtask

  task automatic test_reset_mid();
    int w; logic [2:0] r, g;
    ready_i = 1'b1;
    v[1] = 1'b1; d[1] = mk(HD, 1, 0);
    run_cycle(w, r, g);
    d[1] = mk(BD, 1, 1);
    run_cycle(w, r, g);
    total++; if (grant_o !== 3'b010 || data_o !== mk(BD, 1, 1)) begin bad++; $display("FAIL rm_lock: grant %b data %h want 010/%h", grant_o, data_o, mk(BD, 1, 1)); end
    v[0] = 1'b1; d[0] = mk(SG, 0, 3);
    rstn = 1'b0;
    #1;
    total++; if ({valid_o, grant_o, pkt_cnt_o, err_o, data_o} !== '0) begin bad++; $display("FAIL rm_outputs: valid=%b grant=%b cnt=%h err=%b data=%h want all 0", valid_o, grant_o, pkt_cnt_o, err_o, data_o); end
    total++; if ({C_ready_o, B_ready_o, A_ready_o} !== 3'b000) begin bad++; $display("FAIL rm_ready: got %b want 000", {C_ready_o, B_ready_o, A_ready_o}); end
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    run_cycle(w, r, g);
    total++; if (r !== 3'b001 || data_o !== mk(SG, 0, 3)) begin bad++; $display("FAIL rm_first: ready %b data %h want 001/%h", r, data_o, mk(SG, 0, 3)); end
    v[0] = 1'b0;
    run_cycle(w, r, g);
    total++; if (data_o !== mk(BD, 1, 1) || err_o !== 1'b1 || grant_o !== 3'b000) begin bad++; $display("FAIL rm_orphan: data %h err %b grant %b want %h/1/000", data_o, err_o, grant_o, mk(BD, 1, 1)); end
    idle_inputs();
    run_cycle(w, r, g);
  endtask

  task automatic test_random();
    int w; logic [2:0] r, g, eg;
    for (int c = 0; c < 600; c++) begin
      for (int j = 0; j < 3; j++) begin
        v[j] = ($urandom_range(0, 9) < 7);
        d[j] = mk(2'($urandom_range(0, 3)), j, c);
      end
      ready_i = ($urandom_range(0, 3) != 0);
      eg = exp_grant();
      run_cycle(w, r, g);
      total++; if (r !== exp_ready(w) || g !== eg) begin bad++; $display("FAIL rnd_arb[%0d]: ready %b grant %b want %b/%b", c, r, g, exp_ready(w), eg); end
      total++; if (valid_o !== m_valid || (m_valid && data_o !== m_data)) begin bad++; $display("FAIL rnd_out[%0d]: got %b/%h want %b/%h", c, valid_o, data_o, m_valid, m_data); end
      total++; if (pkt_cnt_o !== m_cnt || err_o !== m_err) begin bad++; $display("FAIL rnd_cnt[%0d]: cnt %0d err %b want %0d/%b", c, pkt_cnt_o, err_o, m_cnt, m_err); end
    end
    idle_inputs();
    ready_i = 1'b1;
    run_cycle(w, r, g);
  endtask

  task automatic test_wrap();
    int w; logic [2:0] r, g;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    model_reset();
    ready_i = 1'b1;
    v[0] = 1'b1; d[0] = mk(SG, 0, 1);
    for (int i = 0; i < 65535; i++) run_cycle(w, r, g);
    total++; if (pkt_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL wrap_full: got %h want ffff", pkt_cnt_o); end
    run_cycle(w, r, g);
    total++; if (pkt_cnt_o !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", pkt_cnt_o); end
    idle_inputs();
  endtask

  initial begin
    rstn = 1'b0;
    ready_i = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_err_body();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
